spi_mem_responder: RTL and testbench

- SPI mode-0 responder: the slave end of the serial memory link the CPU's SPI master drives. Serves as an on-chip or FPGA-side stand-in for the external 23LC-style SPI SRAM/ROM.
- Decodes READ (0x03) and WRITE (0x02) with a 16- or 24-bit address and streams sequential bytes.
- Accesses a byte-wide synchronous memory backend through a simple request port.
- All SPI pins are oversampled in the system clock domain.

---
 rtl/spi_mem_responder_if.sv | 32 +++
 rtl/spi_mem_responder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_responder_if.sv
// spi_mem_responder_if: bundles the SPI pins, the byte-wide memory request port and the
// busy flag of spi_mem_responder.
//   slave  modport: the responder side (drives miso/miso_oe, mem_* requests, busy)
//   master modport: the SPI master plus memory backend side (drives sclk/cs_n/mosi,
//                   addr24 and mem_rdata)
// MEM_AW is the width of mem_addr and must match the responder's MEM_AW.
interface spi_mem_responder_if #(
    parameter int unsigned MEM_AW = 24
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              addr24;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, addr24, mem_rdata,
        output miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    modport master (
        output sclk, cs_n, mosi, addr24, mem_rdata,
        input  miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 slave emulating a 23LC-style serial SRAM/ROM in front of a
// byte-wide synchronous memory. Decodes READ (0x03) and WRITE (0x02) with a 16- or 24-bit
// address and streams sequential bytes. All SPI pins are oversampled in the clk domain
// (clk must be at least 8x sclk).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    spi_mem_responder_if.slave:
//            sclk, cs_n, mosi  SPI inputs (synchronised SYNC_STAGES deep)
//            miso, miso_oe     serial data out and its output enable
//            addr24            1 = 3 address bytes, 0 = 2; latched when cs_n falls
//            mem_addr/mem_wdata/mem_we/mem_re  backend request, one-cycle strobes
//            mem_rdata         backend read data, valid 1 clk after mem_re
//            busy              transaction active
//
// Optional feature macro: SPI_RESPONDER_STATUS_EN adds RDSR (0x05) / WRSR (0x01) and the
// byte / page access modes. Without it those opcodes are ignored and access is sequential.
module spi_mem_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MEM_AW      = 24
) (
    input logic                clk,
    input logic                rst_n,
    spi_mem_responder_if.slave bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StAddr   = 3'd2;
    localparam logic [2:0] StDataRd = 3'd3;
    localparam logic [2:0] StDataWr = 3'd4;
    localparam logic [2:0] StIgnore = 3'd5;
`ifdef SPI_RESPONDER_STATUS_EN
    localparam logic [2:0] StWrsr   = 3'd6;
`endif

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0]  state_q;
    logic [4:0]  bitcnt_q;
    logic [6:0]  shift_q;
    logic [23:0] addr_q;
    logic        addr24_q;
    logic        is_read_q;
    logic [7:0]  tx_q;
    logic        rd_load_q;   // mem_rdata is valid this cycle
    logic        rd_skip_q;   // first sclk fall after loading a byte must not shift
    logic        miso_oe_q;
    logic        mem_we_q, mem_re_q;
    logic [23:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;

    logic [7:0]  rx_byte;
    logic [23:0] addr_shift;
    logic [23:0] addr_inc;
    logic [4:0]  addr_last;
    logic [1:0]  mode;

`ifdef SPI_RESPONDER_STATUS_EN
    logic [1:0]  mode_q;
    logic        status_rd_q;
    assign mode = mode_q;
`else
    assign mode = 2'b01;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign rx_byte    = {shift_q, mosi_s};
    assign addr_shift = {addr_q[22:0], mosi_s};
    assign addr_last  = addr24_q ? 5'd23 : 5'd15;

    // Sequential increment: 16-bit wrap in 2-byte mode, 24-bit otherwise, and wrap inside
    // a 32-byte page in page mode.
    function automatic logic [23:0] next_addr(input logic [23:0] a, input logic wide,
                                              input logic [1:0] m);
        logic [23:0] n;
        n = a + 24'd1;
        if (!wide) begin
            n[23:16] = 8'h00;
        end
        if (m == 2'b10) begin
            n = {a[23:5], n[4:0]};
        end
        return n;
    endfunction

    assign addr_inc = next_addr(addr_q, addr24_q, mode);

    assign bus.miso      = miso_oe_q & tx_q[7];
    assign bus.miso_oe   = miso_oe_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = MEM_AW'(mem_addr_q);
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '0;
            sclk_prev   <= 1'b0;
            cs_prev     <= 1'b1;
            state_q     <= StIdle;
            bitcnt_q    <= 5'd0;
            shift_q     <= 7'd0;
            addr_q      <= 24'd0;
            addr24_q    <= 1'b0;
            is_read_q   <= 1'b0;
            tx_q        <= 8'd0;
            rd_load_q   <= 1'b0;
            rd_skip_q   <= 1'b0;
            miso_oe_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= 24'd0;
            mem_wdata_q <= 8'd0;
`ifdef SPI_RESPONDER_STATUS_EN
            mode_q      <= 2'b01;
            status_rd_q <= 1'b0;
`endif
        end else begin
            sclk_sync[0] <= bus.sclk;
            cs_sync[0]   <= bus.cs_n;
            mosi_sync[0] <= bus.mosi;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;

            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            rd_load_q <= mem_re_q;
            if (rd_load_q && state_q == StDataRd) begin
                tx_q      <= bus.mem_rdata;
                miso_oe_q <= 1'b1;
            end

            // cs_n rising overrides everything, including a byte completing this cycle.
            if (cs_rise) begin
                state_q   <= StIdle;
                miso_oe_q <= 1'b0;
                rd_load_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q  <= StCmd;
                            bitcnt_q <= 5'd0;
                            addr24_q <= bus.addr24;
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            shift_q  <= rx_byte[6:0];
                            bitcnt_q <= bitcnt_q + 5'd1;
                            if (bitcnt_q == 5'd7) begin
                                bitcnt_q <= 5'd0;
                                addr_q   <= 24'd0;
                                case (rx_byte)
                                    8'h03: begin
                                        state_q   <= StAddr;
                                        is_read_q <= 1'b1;
`ifdef SPI_RESPONDER_STATUS_EN
                                        status_rd_q <= 1'b0;
`endif
                                    end
                                    8'h02: begin
                                        state_q   <= StAddr;
                                        is_read_q <= 1'b0;
                                    end
`ifdef SPI_RESPONDER_STATUS_EN
                                    8'h05: begin
                                        state_q     <= StDataRd;
                                        status_rd_q <= 1'b1;
                                        tx_q        <= {mode_q, 6'd0};
                                        miso_oe_q   <= 1'b1;
                                        rd_skip_q   <= 1'b1;
                                    end
                                    8'h01: state_q <= StWrsr;
`endif
                                    default: state_q <= StIgnore;
                                endcase
                            end
                        end
                    end
                    StAddr: begin
                        if (sclk_rise) begin
                            addr_q   <= addr_shift;
                            bitcnt_q <= bitcnt_q + 5'd1;
                            if (bitcnt_q == addr_last) begin
                                bitcnt_q <= 5'd0;
                                if (is_read_q) begin
                                    mem_re_q   <= 1'b1;
                                    mem_addr_q <= addr_shift;
                                    rd_skip_q  <= 1'b1;
                                    state_q    <= StDataRd;
                                end else begin
                                    state_q <= StDataWr;
                                end
                            end
                        end
                    end
                    StDataRd: begin
                        if (sclk_fall) begin
                            if (rd_skip_q) begin
                                rd_skip_q <= 1'b0;
                            end else if (bitcnt_q == 5'd7) begin
                                // Byte done: fetch the next one; it lands in tx_q two clks
                                // later, well before the master's next sampling edge.
                                bitcnt_q <= 5'd0;
`ifdef SPI_RESPONDER_STATUS_EN
                                if (status_rd_q) begin
                                    tx_q <= {mode_q, 6'd0};
                                end else
`endif
                                if (mode == 2'b00) begin
                                    state_q   <= StIgnore;
                                    miso_oe_q <= 1'b0;
                                end else begin
                                    addr_q     <= addr_inc;
                                    mem_addr_q <= addr_inc;
                                    mem_re_q   <= 1'b1;
                                end
                            end else begin
                                tx_q     <= {tx_q[6:0], 1'b0};
                                bitcnt_q <= bitcnt_q + 5'd1;
                            end
                        end
                    end
                    StDataWr: begin
                        if (sclk_rise) begin
                            shift_q  <= rx_byte[6:0];
                            bitcnt_q <= bitcnt_q + 5'd1;
                            if (bitcnt_q == 5'd7) begin
                                bitcnt_q    <= 5'd0;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= rx_byte;
                                mem_addr_q  <= addr_q;
                                addr_q      <= addr_inc;
                                if (mode == 2'b00) begin
                                    state_q <= StIgnore;
                                end
                            end
                        end
                    end
`ifdef SPI_RESPONDER_STATUS_EN
                    StWrsr: begin
                        if (sclk_rise) begin
                            shift_q  <= rx_byte[6:0];
                            bitcnt_q <= bitcnt_q + 5'd1;
                            if (bitcnt_q == 5'd7) begin
                                mode_q  <= rx_byte[7:6];
                                state_q <= StIgnore;
                            end
                        end
                    end
`endif
                    default: ;  // StIgnore: discard until cs_n rises
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: directed bench for spi_mem_responder. Drives SPI mode-0 frames
// (sclk = clk/10), models a byte memory with one-cycle read latency, logs every backend
// strobe and compares against hand-computed expectations.
module tb_spi_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_mem_responder_if #(.MEM_AW(24)) bus ();

    spi_mem_responder #(
        .SYNC_STAGES(2),
        .MEM_AW     (24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Backend memory: read data valid the cycle after mem_re.
    logic [7:0] mem [logic [23:0]];
    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
        end
    end

    logic [23:0] we_addr_q[$];
    logic [7:0]  we_data_q[$];
    logic [23:0] re_addr_q[$];
    int          n_overlap  = 0;
    int          n_miso_leak = 0;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_addr_q.push_back(bus.mem_addr);
            we_data_q.push_back(bus.mem_wdata);
        end
        if (bus.mem_re) re_addr_q.push_back(bus.mem_addr);
        if (bus.mem_we && bus.mem_re) n_overlap++;
        if (!bus.miso_oe && bus.miso) n_miso_leak++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
    endtask

    // Shift nbits of tx MSB first; sample miso and miso_oe on each rising sclk edge.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic [7:0] oe);
        rx = 8'h00;
        oe = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            #50;
            bus.sclk  = 1'b1;
            rx[7-i]   = bus.miso;
            oe[7-i]   = bus.miso_oe;
            #50;
            bus.sclk  = 1'b0;
        end
    endtask

    task automatic cs_begin(input logic wide);
        bus.addr24 = wide;
        bus.cs_n   = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100;
        bus.cs_n = 1'b1;
        #200;
    endtask

    logic [7:0] rx, oe, rx0, rx1, oe_hdr, oe_dat;

    initial begin
        bus.sclk   = 1'b0;
        bus.cs_n   = 1'b1;
        bus.mosi   = 1'b0;
        bus.addr24 = 1'b0;
        mem[24'h010000] = 8'h5A;
        mem[24'h010001] = 8'hC3;
        mem[24'h00FFFF] = 8'h11;
        mem[24'h000000] = 8'h22;
        mem[24'h000300] = 8'hA1;
        mem[24'h000301] = 8'hB2;

        // Reset state
        #20;
        check("reset_ctl", {27'd0, bus.busy, bus.miso_oe, bus.miso, bus.mem_we, bus.mem_re},
              32'd0);
        check("reset_addr", 32'(bus.mem_addr), 32'd0);
        check("reset_wdata", 32'(bus.mem_wdata), 32'd0);
        #40;
        rst_n = 1'b1;
        #100;

        // Write, 16-bit address
        clear_logs();
        cs_begin(1'b0);
        check("wr16_busy", 32'(bus.busy), 32'd1);
        spi_xfer(8'h02, 8, rx, oe);
        spi_xfer(8'h12, 8, rx, oe);
        spi_xfer(8'h34, 8, rx, oe);
        spi_xfer(8'hAA, 8, rx, oe);
        spi_xfer(8'hBB, 8, rx, oe);
        cs_end();
        check("wr16_count", 32'(we_addr_q.size()), 32'd2);
        check("wr16_addr0", 32'(we_addr_q[0]), 32'h001234);
        check("wr16_data0", 32'(we_data_q[0]), 32'hAA);
        check("wr16_addr1", 32'(we_addr_q[1]), 32'h001235);
        check("wr16_data1", 32'(we_data_q[1]), 32'hBB);
        check("wr16_no_re", 32'(re_addr_q.size()), 32'd0);
        check("wr16_idle", 32'(bus.busy), 32'd0);

        // Read, 24-bit address
        clear_logs();
        cs_begin(1'b1);
        oe_hdr = 8'h00;
        spi_xfer(8'h03, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h01, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h00, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h00, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h00, 8, rx0, oe_dat);
        spi_xfer(8'h00, 8, rx1, oe);
        oe_dat &= oe;
        cs_end();
        check("rd24_byte0", 32'(rx0), 32'h5A);
        check("rd24_byte1", 32'(rx1), 32'hC3);
        check("rd24_oe_hdr", 32'(oe_hdr), 32'h00);
        check("rd24_oe_data", 32'(oe_dat), 32'hFF);
        check("rd24_re0", 32'(re_addr_q[0]), 32'h010000);
        check("rd24_re1", 32'(re_addr_q[1]), 32'h010001);
        check("rd24_no_we", 32'(we_addr_q.size()), 32'd0);
        check("rd24_oe_off", 32'(bus.miso_oe), 32'd0);

        // 16-bit address wrap
        clear_logs();
        cs_begin(1'b0);
        spi_xfer(8'h03, 8, rx, oe);
        spi_xfer(8'hFF, 8, rx, oe);
        spi_xfer(8'hFF, 8, rx, oe);
        spi_xfer(8'h00, 8, rx0, oe);
        spi_xfer(8'h00, 8, rx1, oe);
        cs_end();
        check("wrap_re0", 32'(re_addr_q[0]), 32'h00FFFF);
        check("wrap_re1", 32'(re_addr_q[1]), 32'h000000);
        check("wrap_byte0", 32'(rx0), 32'h11);
        check("wrap_byte1", 32'(rx1), 32'h22);

        // Abort: partial data byte is dropped, next frame decodes normally
        clear_logs();
        cs_begin(1'b0);
        spi_xfer(8'h02, 8, rx, oe);
        spi_xfer(8'h00, 8, rx, oe);
        spi_xfer(8'h10, 8, rx, oe);
        spi_xfer(8'hFF, 5, rx, oe);
        check("abort_busy_hi", 32'(bus.busy), 32'd1);
        cs_end();
        check("abort_no_we", 32'(we_addr_q.size()), 32'd0);
        check("abort_busy_lo", 32'(bus.busy), 32'd0);
        cs_begin(1'b0);
        spi_xfer(8'h02, 8, rx, oe);
        spi_xfer(8'h00, 8, rx, oe);
        spi_xfer(8'h20, 8, rx, oe);
        spi_xfer(8'h5C, 8, rx, oe);
        cs_end();
        check("after_abort_count", 32'(we_addr_q.size()), 32'd1);
        check("after_abort_addr", 32'(we_addr_q[0]), 32'h000020);
        check("after_abort_data", 32'(we_data_q[0]), 32'h5C);

        // Unknown opcode 0x9F, then 0x05 (ignored without the status feature)
        clear_logs();
        oe_hdr = 8'h00;
        cs_begin(1'b0);
        spi_xfer(8'h9F, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h11, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h22, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h33, 8, rx, oe); oe_hdr |= oe;
        cs_end();
        cs_begin(1'b0);
        spi_xfer(8'h05, 8, rx, oe); oe_hdr |= oe;
        spi_xfer(8'h00, 8, rx, oe); oe_hdr |= oe;
        cs_end();
        check("unk_no_we", 32'(we_addr_q.size()), 32'd0);
        check("unk_no_re", 32'(re_addr_q.size()), 32'd0);
        check("unk_oe", 32'(oe_hdr), 32'h00);

        // Reset during the second data byte of a read
        clear_logs();
        cs_begin(1'b0);
        spi_xfer(8'h03, 8, rx, oe);
        spi_xfer(8'h03, 8, rx, oe);
        spi_xfer(8'h00, 8, rx, oe);
        spi_xfer(8'h00, 8, rx0, oe);
        spi_xfer(8'h00, 3, rx, oe);
        check("rst_mid_byte0", 32'(rx0), 32'hA1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl",
              {27'd0, bus.busy, bus.miso_oe, bus.miso, bus.mem_we, bus.mem_re}, 32'd0);
        check("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
        #19;
        bus.cs_n = 1'b1;
        #100;
        rst_n = 1'b1;
        #100;
        clear_logs();
        cs_begin(1'b0);
        spi_xfer(8'h03, 8, rx, oe);
        spi_xfer(8'h03, 8, rx, oe);
        spi_xfer(8'h01, 8, rx, oe);
        spi_xfer(8'h00, 8, rx0, oe);
        cs_end();
        check("rst_after_byte", 32'(rx0), 32'hB2);
        check("rst_after_re0", 32'(re_addr_q[0]), 32'h000301);

        check("we_re_overlap", 32'(n_overlap), 32'd0);
        check("miso_without_oe", 32'(n_miso_leak), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
